// File: rtl/window3x3_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : window3x3_line_buffer
// Purpose  : Raster pixel stream to 3x3 neighbourhood window using two line
//            buffers and three 3-tap shift rows; per-frame done / sof error.
// Revision : 1.0 - initial release
// ============================================================================
module window3x3_line_buffer #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] pix_i,
   input  logic              valid_i,
   input  logic              sof_i,
   output logic [DATA_W-1:0] d0_o,
   output logic [DATA_W-1:0] d1_o,
   output logic [DATA_W-1:0] d2_o,
   output logic [DATA_W-1:0] d3_o,
   output logic [DATA_W-1:0] d4_o,
   output logic [DATA_W-1:0] d5_o,
   output logic [DATA_W-1:0] d6_o,
   output logic [DATA_W-1:0] d7_o,
   output logic [DATA_W-1:0] d8_o,
   output logic              valid_o,
   output logic              done_o,
   output logic              sof_err_o
);

   localparam int c_col_w = $clog2(IMG_W);
   localparam int c_row_w = $clog2(IMG_H);
   localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IMG_W - 1);
   localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IMG_H - 1);
   localparam logic [c_col_w-1:0] c_col_two  = c_col_w'(2);
   localparam logic [c_row_w-1:0] c_row_two  = c_row_w'(2);

   logic [c_col_w-1:0] r_col, w_col, w_col_nxt;
   logic [c_row_w-1:0] r_row, w_row, w_row_nxt;
   logic               w_restart, w_err, w_win, w_last;

   logic [DATA_W-1:0]  r_lb0 [IMG_W];
   logic [DATA_W-1:0]  r_lb1 [IMG_W];
   logic [DATA_W-1:0]  r_tap [9];
   logic [DATA_W-1:0]  w_tap_nxt [9];
   logic [DATA_W-1:0]  r_d [9];

   // A start-of-frame pixel is always treated as position (0,0).
   always_comb begin
      w_restart = valid_i & sof_i;
      w_err     = w_restart & ((r_col != '0) | (r_row != '0));
      w_col     = w_restart ? '0 : r_col;
      w_row     = w_restart ? '0 : r_row;
      w_win     = valid_i & ~w_err & (w_row >= c_row_two) & (w_col >= c_col_two);
      w_last    = w_win & (w_row == c_row_last) & (w_col == c_col_last);

      w_col_nxt = w_col + c_col_w'(1);
      w_row_nxt = w_row;
      if (w_col == c_col_last) begin
         w_col_nxt = '0;
         w_row_nxt = (w_row == c_row_last) ? '0 : w_row + c_row_w'(1);
      end

      w_tap_nxt[0] = r_tap[1];
      w_tap_nxt[1] = r_tap[2];
      w_tap_nxt[2] = r_lb0[w_col];
      w_tap_nxt[3] = r_tap[4];
      w_tap_nxt[4] = r_tap[5];
      w_tap_nxt[5] = r_lb1[w_col];
      w_tap_nxt[6] = r_tap[7];
      w_tap_nxt[7] = r_tap[8];
      w_tap_nxt[8] = pix_i;
   end

   // Line RAM: read-before-write, no reset (always written before being read).
   always_ff @(posedge clk) begin
      if (valid_i) begin
         r_lb0[w_col] <= r_lb1[w_col];
         r_lb1[w_col] <= pix_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col     <= '0;
         r_row     <= '0;
         valid_o   <= 1'b0;
         done_o    <= 1'b0;
         sof_err_o <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            r_tap[i] <= '0;
            r_d[i]   <= '0;
         end
      end else begin
         valid_o   <= w_win;
         done_o    <= w_last;
         sof_err_o <= w_err;
         if (valid_i) begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
            r_tap <= w_tap_nxt;
         end
         // Output taps only change when a real window is produced.
         if (w_win) begin
            r_d <= w_tap_nxt;
         end
      end
   end

   assign d0_o = r_d[0];
   assign d1_o = r_d[1];
   assign d2_o = r_d[2];
   assign d3_o = r_d[3];
   assign d4_o = r_d[4];
   assign d5_o = r_d[5];
   assign d6_o = r_d[6];
   assign d7_o = r_d[7];
   assign d8_o = r_d[8];

endmodule
`default_nettype wire

// File: tb/tb_window3x3_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_window3x3_line_buffer
// Purpose  : Self-checking bench: 5x4 8-bit instance against an image model
//            scoreboard, and a 3x3 10-bit instance against a vector table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_window3x3_line_buffer;

   localparam int W = 5;
   localparam int H = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [7:0]       pix_a;
   logic             valid_a, sof_a;
   logic [8:0][7:0]  da;
   logic             va, done_a, err_a;

   logic [9:0]       pix_b;
   logic             valid_b, sof_b;
   logic [8:0][9:0]  db;
   logic             vb, done_b, err_b;

   window3x3_line_buffer #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut_a (
      .clk(clk), .rst(rst), .pix_i(pix_a), .valid_i(valid_a), .sof_i(sof_a),
      .d0_o(da[0]), .d1_o(da[1]), .d2_o(da[2]), .d3_o(da[3]), .d4_o(da[4]),
      .d5_o(da[5]), .d6_o(da[6]), .d7_o(da[7]), .d8_o(da[8]),
      .valid_o(va), .done_o(done_a), .sof_err_o(err_a)
   );

   window3x3_line_buffer #(.DATA_W(10), .IMG_W(3), .IMG_H(3)) dut_b (
      .clk(clk), .rst(rst), .pix_i(pix_b), .valid_i(valid_b), .sof_i(sof_b),
      .d0_o(db[0]), .d1_o(db[1]), .d2_o(db[2]), .d3_o(db[3]), .d4_o(db[4]),
      .d5_o(db[5]), .d6_o(db[6]), .d7_o(db[7]), .d8_o(db[8]),
      .valid_o(vb), .done_o(done_b), .sof_err_o(err_b)
   );

   typedef struct packed {
      logic            v;
      logic            done;
      logic            err;
      logic [8:0][7:0] d;
   } exp_t;

   typedef struct packed {
      logic            v;
      logic            s;
      logic [9:0]      p;
      logic            ev;
      logic            ed;
      logic            ee;
      logic [8:0][9:0] edd;
   } vec_t;

   exp_t q[$];
   int   vec_cnt = 0;
   int   err_cnt = 0;
   int   win_cnt = 0;
   int   done_cnt = 0;
   int   serr_cnt = 0;

   // Reference model state: full image array plus last emitted window.
   logic [7:0]      img [H][W];
   int              m_r, m_c;
   logic [8:0][7:0] m_d;

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         vec_cnt++;
         if ({va, done_a, err_a, da} !== {e.v, e.done, e.err, e.d}) begin
            err_cnt++;
            $display("FAIL scoreboard t=%0t: got v=%b done=%b err=%b d=%h, want v=%b done=%b err=%b d=%h",
                     $time, va, done_a, err_a, da, e.v, e.done, e.err, e.d);
         end
      end
      if (va === 1'b1)     win_cnt++;
      if (done_a === 1'b1) done_cnt++;
      if (err_a === 1'b1)  serr_cnt++;
   end

   task automatic chk(input string name, input int act, input int exp);
      vec_cnt++;
      if (act != exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic drive(input logic v, input logic s, input logic [7:0] p);
      exp_t e;
      @(negedge clk);
      valid_a = v;
      sof_a   = s;
      pix_a   = p;
      e.v = 1'b0; e.done = 1'b0; e.err = 1'b0;
      if (v) begin
         if (s) begin
            e.err = (m_r != 0 || m_c != 0);
            m_r = 0;
            m_c = 0;
         end
         img[m_r][m_c] = p;
         if (m_r >= 2 && m_c >= 2) begin
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  m_d[i*3+j] = img[m_r-2+i][m_c-2+j];
            e.v    = 1'b1;
            e.done = (m_r == H-1 && m_c == W-1);
         end
         if (m_c == W-1) begin
            m_c = 0;
            m_r = (m_r == H-1) ? 0 : m_r + 1;
         end else begin
            m_c++;
         end
      end
      e.d = m_d;
      q.push_back(e);
   endtask

   task automatic frame(input logic [7:0] base, input bit use_sof, input bit stall);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            while (stall && $urandom_range(1, 0) == 1)
               drive(1'b0, 1'b0, 8'($urandom));
            drive(1'b1, use_sof && r == 0 && c == 0, 8'(base + r*16 + c));
         end
   endtask

   task automatic drain();
      drive(1'b0, 1'b0, 8'h00);
      @(posedge clk);
      #2;
   endtask

   task automatic clr_cnt();
      win_cnt = 0; done_cnt = 0; serr_cnt = 0;
   endtask

   vec_t            tbl [10];
   logic [8:0][9:0] wexp;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      valid_a = 1'b0; sof_a = 1'b0; pix_a = '0;
      valid_b = 1'b0; sof_b = 1'b0; pix_b = '0;
      m_r = 0; m_c = 0; m_d = '0;
      #2;
      chk("reset_a", int'({va, done_a, err_a, da} != '0), 0);
      chk("reset_b", int'({vb, done_b, err_b, db} != '0), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // 3x3 10-bit frame: all 0x3FF except a zero centre pixel.
      wexp = {9{10'h3FF}};
      wexp[4] = 10'h000;
      for (int i = 0; i < 9; i++) begin
         tbl[i].v   = 1'b1;
         tbl[i].s   = 1'b0;
         tbl[i].p   = (i == 4) ? 10'h000 : 10'h3FF;
         tbl[i].ev  = (i == 8);
         tbl[i].ed  = (i == 8);
         tbl[i].ee  = 1'b0;
         tbl[i].edd = (i == 8) ? wexp : '0;
      end
      tbl[9].v = 1'b0; tbl[9].s = 1'b0; tbl[9].p = 10'h155;
      tbl[9].ev = 1'b0; tbl[9].ed = 1'b0; tbl[9].ee = 1'b0; tbl[9].edd = wexp;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         valid_b = tbl[i].v; sof_b = tbl[i].s; pix_b = tbl[i].p;
         @(posedge clk);
         #1;
         vec_cnt++;
         if ({vb, done_b, err_b, db} !== {tbl[i].ev, tbl[i].ed, tbl[i].ee, tbl[i].edd}) begin
            err_cnt++;
            $display("FAIL table[%0d]: got v=%b done=%b err=%b d=%h, want v=%b done=%b err=%b d=%h",
                     i, vb, done_b, err_b, db, tbl[i].ev, tbl[i].ed, tbl[i].ee, tbl[i].edd);
         end
      end

      // Continuous frame.
      clr_cnt();
      frame(8'h00, 1'b0, 1'b0);
      drain();
      chk("s1_windows", win_cnt, 6);
      chk("s1_done", done_cnt, 1);
      chk("s1_sof_err", serr_cnt, 0);
      chk("s1_last_d8", int'(da[8]), 8'h34);
      chk("s1_last_d0", int'(da[0]), 8'h12);

      // Stalled stream.
      clr_cnt();
      frame(8'h00, 1'b1, 1'b1);
      drain();
      chk("s2_windows", win_cnt, 6);
      chk("s2_done", done_cnt, 1);
      chk("s2_sof_err", serr_cnt, 0);

      // Back-to-back frames.
      clr_cnt();
      frame(8'h00, 1'b1, 1'b0);
      frame(8'h80, 1'b1, 1'b0);
      drain();
      chk("s3_windows", win_cnt, 12);
      chk("s3_done", done_cnt, 2);
      chk("s3_sof_err", serr_cnt, 0);

      // Early sof at (2,3) after pixels (0,0)..(2,2).
      clr_cnt();
      for (int k = 0; k < 2*W + 3; k++)
         drive(1'b1, 1'b0, 8'((k / W) * 16 + (k % W)));
      frame(8'h40, 1'b1, 1'b0);
      drain();
      chk("s4_windows", win_cnt, 7);
      chk("s4_done", done_cnt, 1);
      chk("s4_sof_err", serr_cnt, 1);

      // Reset with counters at (3,1).
      clr_cnt();
      for (int k = 0; k < 3*W + 1; k++)
         drive(1'b1, 1'b0, 8'(8'h08 + (k / W) * 16 + (k % W)));
      drain();
      chk("s5_pre_nonzero", int'(da != '0), 1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("s5_async_reset", int'({va, done_a, err_a, da} != '0), 0);
      m_r = 0; m_c = 0; m_d = '0;
      @(negedge clk);
      rst = 1'b0;
      frame(8'h20, 1'b0, 1'b0);
      drain();
      chk("s5_windows", win_cnt, 9);
      chk("s5_done", done_cnt, 1);
      chk("s5_sof_err", serr_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
`default_nettype wire
